resblock_residual_pack: RTL and testbench

- Downstream of the resblock forwarding mux.
- Adds the four forwarded residual activations (LU/RU/LD/RD) to the matching four conv accumulator results, then rounds, saturates and applies optional ReLU.
- Packs the per-channel results over CH_NUM channels into one full activation-SRAM write word.
- Presents the word with its address on a valid/ready interface to the SRAM write arbiter. A one-word output register lets the next word fill while the previous one waits.

---
 rtl/resblock_residual_pack.sv | 142 ++++++++++++++
 tb/tb_resblock_residual_pack.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/resblock_residual_pack.sv
// Purpose: adds forwarded residuals to conv accumulators, rounds/saturates/ReLUs, packs CH_NUM channels into one SRAM word.
// Latency: last channel beat at cycle t -> out_valid at t+1 when the output register is free.
// Backpressure: one-word output register plus pack buffer; when both are full, in_ready drops (HOLD) until out_ready.
// Ports: clk/rst (async active-high); in_valid/in_ready/fmap_idx/in_addr/res_en/relu_en plus conv_* and *_forwarding
// on the channel side; out_valid/out_ready/out_wdata/out_addr toward the SRAM write arbiter; err_seq sticky flag.
module resblock_residual_pack #(
  parameter int CH_NUM       = 24,
  parameter int ACT_PER_ADDR = 4,
  parameter int BW_PER_ACT   = 16,
  parameter int BW_ACC       = 32,
  parameter int FRAC_SHIFT   = 8,
  parameter int ADDR_BW      = 10
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [6:0]                                  fmap_idx,
  input  logic [ADDR_BW-1:0]                          in_addr,
  input  logic                                        res_en,
  input  logic                                        relu_en,
  input  logic signed [BW_ACC-1:0]                    conv_lu,
  input  logic signed [BW_ACC-1:0]                    conv_ru,
  input  logic signed [BW_ACC-1:0]                    conv_ld,
  input  logic signed [BW_ACC-1:0]                    conv_rd,
  input  logic signed [BW_PER_ACT-1:0]                LU_forwarding,
  input  logic signed [BW_PER_ACT-1:0]                RU_forwarding,
  input  logic signed [BW_PER_ACT-1:0]                LD_forwarding,
  input  logic signed [BW_PER_ACT-1:0]                RD_forwarding,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]   out_wdata,
  output logic [ADDR_BW-1:0]                          out_addr,
  output logic                                        err_seq
);

  localparam int TOTAL = CH_NUM * ACT_PER_ADDR * BW_PER_ACT;
  localparam int GRP   = ACT_PER_ADDR * BW_PER_ACT;
  localparam int EXT   = BW_ACC + 2;
  localparam logic signed [EXT-1:0] SAT_MAX = EXT'((1 << (BW_PER_ACT - 1)) - 1);
  localparam logic signed [EXT-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic signed [EXT-1:0] RND     = EXT'(1 << (FRAC_SHIFT - 1));
  localparam logic [6:0]            LAST    = 7'(CH_NUM - 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                 state, state_nxt;
  logic [6:0]             ch_cnt;
  logic [TOTAL-1:0]       pack_buf, next_buf;
  logic [ADDR_BW-1:0]     word_addr;
  logic [GRP-1:0]         ch_res;
  logic                   accept, last_beat, load_out;
  logic [ADDR_BW-1:0]     load_addr;

  // Residual add at EXT bits so conv + shifted residual + rounding cannot wrap.
  function automatic logic [BW_PER_ACT-1:0] requant(
    input logic signed [BW_ACC-1:0]     conv,
    input logic signed [BW_PER_ACT-1:0] fwd,
    input logic                         add_res,
    input logic                         relu
  );
    logic signed [EXT-1:0] r;
    logic signed [EXT-1:0] s;
    logic signed [EXT-1:0] sat;
    r = add_res ? ({{(EXT-BW_PER_ACT){fwd[BW_PER_ACT-1]}}, fwd} <<< FRAC_SHIFT) : '0;
    s = {{2{conv[BW_ACC-1]}}, conv} + r + RND;
    s = s >>> FRAC_SHIFT;
    if (s > SAT_MAX)      sat = SAT_MAX;
    else if (s < SAT_MIN) sat = SAT_MIN;
    else                  sat = s;
    if (relu && sat[EXT-1]) sat = '0;
    return sat[BW_PER_ACT-1:0];
  endfunction

  // Group layout: RD at the MSB end, LU at the LSB end.
  assign ch_res = {requant(conv_rd, RD_forwarding, res_en, relu_en),
                   requant(conv_ld, LD_forwarding, res_en, relu_en),
                   requant(conv_ru, RU_forwarding, res_en, relu_en),
                   requant(conv_lu, LU_forwarding, res_en, relu_en)};

  assign accept    = in_valid && in_ready;
  assign last_beat = accept && (ch_cnt == LAST);
  // In HOLD the output register is necessarily full, so only out_ready matters.
  assign load_out  = (last_beat && (!out_valid || out_ready)) || (state == HOLD && out_ready);
  // Single-channel words capture the address on the completing beat itself.
  assign load_addr = (last_beat && ch_cnt == '0) ? in_addr : word_addr;

  // Buffer image including the current beat, so a completing word can load straight out.
  always_comb begin
    next_buf = pack_buf;
    if (accept) begin
      for (int c = 0; c < CH_NUM; c++) begin
        if (fmap_idx == 7'(c)) next_buf[TOTAL-GRP*(c+1) +: GRP] = ch_res;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if (last_beat && out_valid && !out_ready) state_nxt = HOLD;
      HOLD: if (out_ready) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    in_ready = (state == FILL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_cnt    <= '0;
      pack_buf  <= '0;
      word_addr <= '0;
      err_seq   <= 1'b0;
      out_valid <= 1'b0;
      out_wdata <= '0;
      out_addr  <= '0;
    end else begin
      pack_buf <= next_buf;
      if (accept) begin
        ch_cnt <= (ch_cnt == LAST) ? 7'd0 : ch_cnt + 7'd1;
        if (fmap_idx != ch_cnt) err_seq <= 1'b1;
        if (ch_cnt == '0) word_addr <= in_addr;
      end
      if (load_out) begin
        out_wdata <= next_buf;
        out_addr  <= load_addr;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_resblock_residual_pack.sv
module tb_resblock_residual_pack;
  localparam int TOTAL = 24 * 4 * 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid, in_ready;
  logic [6:0]         fmap_idx;
  logic [9:0]         in_addr;
  logic               res_en, relu_en;
  logic signed [31:0] conv_lu, conv_ru, conv_ld, conv_rd;
  logic signed [15:0] LU_forwarding, RU_forwarding, LD_forwarding, RD_forwarding;
  logic               out_valid, out_ready;
  logic [TOTAL-1:0]   out_wdata;
  logic [9:0]         out_addr;
  logic               err_seq;

  int checks = 0;
  int failures = 0;
  logic [15:0]      exp_lane [24][4];
  logic [TOTAL-1:0] w_exp, w_hold;

  always #5 clk = ~clk;

  resblock_residual_pack dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fmap_idx(fmap_idx), .in_addr(in_addr), .res_en(res_en), .relu_en(relu_en),
    .conv_lu(conv_lu), .conv_ru(conv_ru), .conv_ld(conv_ld), .conv_rd(conv_rd),
    .LU_forwarding(LU_forwarding), .RU_forwarding(RU_forwarding),
    .LD_forwarding(LD_forwarding), .RD_forwarding(RD_forwarding),
    .out_valid(out_valid), .out_ready(out_ready), .out_wdata(out_wdata),
    .out_addr(out_addr), .err_seq(err_seq)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [TOTAL-1:0] pack_exp();
    logic [TOTAL-1:0] w = '0;
    for (int c = 0; c < 24; c++)
      for (int k = 0; k < 4; k++)
        w[TOTAL-64*(c+1)+16*k +: 16] = exp_lane[c][k];
    return w;
  endfunction

  task automatic check_word(input string tag, input logic [TOTAL-1:0] ew);
    for (int c = 0; c < 24; c++)
      chk($sformatf("%s_ch%0d", tag, c), out_wdata[TOTAL-64*(c+1) +: 64], ew[TOTAL-64*(c+1) +: 64]);
  endtask

  // Presents the driven beat; called at a falling edge, returns at the next falling edge.
  task automatic beat();
    int n = 0;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("beat_in_ready_timeout", {63'b0, in_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Pattern beat: each lane = base + idx*4 + k, no residual, no ReLU.
  task automatic pbeat(input int idx, input logic [9:0] addr, input int base);
    fmap_idx = 7'(idx);
    in_addr  = addr;
    res_en   = 1'b1;
    relu_en  = 1'b0;
    conv_lu  = 32'((base + idx*4 + 0) << 8);
    conv_ru  = 32'((base + idx*4 + 1) << 8);
    conv_ld  = 32'((base + idx*4 + 2) << 8);
    conv_rd  = 32'((base + idx*4 + 3) << 8);
    LU_forwarding = '0; RU_forwarding = '0; LD_forwarding = '0; RD_forwarding = '0;
    for (int k = 0; k < 4; k++) exp_lane[idx][k] = 16'(base + idx*4 + k);
    beat();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; fmap_idx = '0; in_addr = '0; res_en = 1'b0; relu_en = 1'b0;
    conv_lu = '0; conv_ru = '0; conv_ld = '0; conv_rd = '0;
    LU_forwarding = '0; RU_forwarding = '0; LD_forwarding = '0; RD_forwarding = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 24; c++) for (int k = 0; k < 4; k++) exp_lane[c][k] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_wdata_zero", {63'b0, |out_wdata}, 64'd0);
    chk("rst_out_addr", {54'b0, out_addr}, 64'd0);
    chk("rst_err_seq", {63'b0, err_seq}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", {63'b0, in_ready}, 64'd1);

    // Word 1: arithmetic corner cases on channels 0..2, address captured on channel 0 only
    fmap_idx = 7'd0; in_addr = 10'h155; res_en = 1'b1; relu_en = 1'b0;
    conv_lu = 32'sd2688; conv_ru = -32'sd384; conv_ld = 32'h7FFF0000; conv_rd = 32'h500;
    LU_forwarding = 16'sd5; RU_forwarding = 16'sd0; LD_forwarding = 16'sd100; RD_forwarding = 16'sd2;
    exp_lane[0][0] = 16'd16; exp_lane[0][1] = 16'hFFFF; exp_lane[0][2] = 16'h7FFF; exp_lane[0][3] = 16'd7;
    beat();
    in_addr = 10'h2A0;
    fmap_idx = 7'd1; relu_en = 1'b1;
    conv_lu = 32'sd768; conv_ru = -32'sd512; conv_ld = 32'sd0; conv_rd = -32'sh10000;
    LU_forwarding = 16'sd0; RU_forwarding = 16'sd1; LD_forwarding = -16'sd3; RD_forwarding = 16'sd0;
    exp_lane[1][0] = 16'd3; exp_lane[1][1] = 16'd0; exp_lane[1][2] = 16'd0; exp_lane[1][3] = 16'd0;
    beat();
    fmap_idx = 7'd2; res_en = 1'b0; relu_en = 1'b0;
    conv_lu = 32'sd256; conv_ru = 32'h1000; conv_ld = 32'h80000000; conv_rd = -32'sd256;
    LU_forwarding = 16'sd1000; RU_forwarding = 16'sd5; LD_forwarding = 16'sd0; RD_forwarding = -16'sd5;
    exp_lane[2][0] = 16'd1; exp_lane[2][1] = 16'd16; exp_lane[2][2] = 16'h8000; exp_lane[2][3] = 16'hFFFF;
    beat();
    for (int c = 3; c < 23; c++) pbeat(c, 10'h2A0, 0);
    chk("w1_no_early_valid", {63'b0, out_valid}, 64'd0);
    pbeat(23, 10'h2A0, 0);
    chk("w1_valid_t_plus_1", {63'b0, out_valid}, 64'd1);
    chk("w1_addr", {54'b0, out_addr}, 64'h155);
    chk("w1_err_seq", {63'b0, err_seq}, 64'd0);
    chk("w1_ch0_lu", {48'b0, out_wdata[TOTAL-64 +: 16]}, 64'd16);
    chk("w1_ch0_ru", {48'b0, out_wdata[TOTAL-48 +: 16]}, 64'hFFFF);
    chk("w1_ch0_ld_sat", {48'b0, out_wdata[TOTAL-32 +: 16]}, 64'h7FFF);
    chk("w1_ch0_rd_top", {48'b0, out_wdata[TOTAL-1 -: 16]}, 64'd7);
    chk("w1_ch1_rd_relu", {48'b0, out_wdata[TOTAL-128+48 +: 16]}, 64'd0);
    chk("w1_ch2_lu_nores", {48'b0, out_wdata[TOTAL-192 +: 16]}, 64'd1);
    check_word("w1", pack_exp());
    @(negedge clk);
    chk("w1_valid_drop", {63'b0, out_valid}, 64'd0);

    // Backpressure: word 2 waits in the output register, word 3 fills then holds
    out_ready = 1'b0;
    for (int c = 0; c < 24; c++) pbeat(c, 10'h0AA, 100);
    w_hold = pack_exp();
    chk("bp_w2_valid", {63'b0, out_valid}, 64'd1);
    chk("bp_w2_addr", {54'b0, out_addr}, 64'h0AA);
    chk("bp_fill_ready", {63'b0, in_ready}, 64'd1);
    for (int c = 0; c < 24; c++) pbeat(c, 10'h0BB, 200);
    w_exp = pack_exp();
    chk("bp_hold_ready", {63'b0, in_ready}, 64'd0);
    chk("bp_hold_valid", {63'b0, out_valid}, 64'd1);
    chk("bp_hold_addr", {54'b0, out_addr}, 64'h0AA);
    check_word("bp_hold_w2", w_hold);
    repeat (3) @(negedge clk);
    chk("bp_still_hold", {63'b0, in_ready}, 64'd0);
    check_word("bp_stable_w2", w_hold);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_w3_valid", {63'b0, out_valid}, 64'd1);
    chk("bp_w3_addr", {54'b0, out_addr}, 64'h0BB);
    chk("bp_ready_back", {63'b0, in_ready}, 64'd1);
    check_word("bp_w3", w_exp);
    @(negedge clk);
    chk("bp_w3_drained", {63'b0, out_valid}, 64'd0);

    // Sequence error: 0 then 2; slot 1 keeps word 3 data
    pbeat(0, 10'h111, 300);
    chk("seq_ok_first", {63'b0, err_seq}, 64'd0);
    pbeat(2, 10'h111, 300);
    chk("seq_err_set", {63'b0, err_seq}, 64'd1);
    for (int c = 2; c < 24; c++) pbeat(c, 10'h111, 300);
    chk("seq_w4_valid", {63'b0, out_valid}, 64'd1);
    chk("seq_w4_addr", {54'b0, out_addr}, 64'h111);
    check_word("seq_w4", pack_exp());
    for (int c = 0; c < 24; c++) pbeat(c, 10'h222, 400);
    chk("seq_err_sticky", {63'b0, err_seq}, 64'd1);
    chk("seq_w5_addr", {54'b0, out_addr}, 64'h222);

    // Reset mid-word
    for (int c = 0; c < 10; c++) pbeat(c, 10'h333, 500);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {63'b0, out_valid}, 64'd0);
    chk("mid_rst_err", {63'b0, err_seq}, 64'd0);
    chk("mid_rst_wdata", {63'b0, |out_wdata}, 64'd0);
    for (int c = 0; c < 24; c++) for (int k = 0; k < 4; k++) exp_lane[c][k] = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", {63'b0, in_ready}, 64'd1);
    chk("mid_rst_valid_after", {63'b0, out_valid}, 64'd0);
    for (int c = 0; c < 24; c++) pbeat(c, 10'h3FF, 600);
    chk("w6_valid", {63'b0, out_valid}, 64'd1);
    chk("w6_addr", {54'b0, out_addr}, 64'h3FF);
    chk("w6_err_seq", {63'b0, err_seq}, 64'd0);
    check_word("w6", pack_exp());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
